bus_matrix: RTL

//   Parametrised single-layer system bus: NUM_MASTERS masters share one path to NUM_SLAVES

---
 rtl/bus_matrix_pkg.sv | 20 ++
 rtl/bus_matrix_if.sv | 39 +++
 rtl/bus_matrix_rr_arbiter.sv | 33 +++
 rtl/bus_matrix.sv | 118 +++++++++++
 4 files changed

// File: rtl/bus_matrix_pkg.sv
// Shared defaults, FSM encoding and sizing helper for the single-layer bus matrix.
package bus_matrix_pkg;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_SLAVES  = 4;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_WIN_LSB     = 11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_matrix_if.sv
// Master- and slave-side signal bundle of the bus matrix; per-master fields are packed arrays.
interface bus_matrix_if
    import bus_matrix_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
);
    logic [NUM_MASTERS-1:0]             m_req;
    logic [NUM_MASTERS-1:0]             m_wr;
    logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0][DATA_W-1:0] m_dout;
    logic [NUM_MASTERS-1:0]             m_grant;
    logic [DATA_W-1:0]                  m_din;
    logic                               m_err;

    logic [NUM_SLAVES-1:0]              s_sel;
    logic                               s_wr;
    logic [ADDR_W-1:0]                  s_addr;
    logic [DATA_W-1:0]                  s_din;
    logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_dout;

    modport matrix (
        input  m_req, m_wr, m_addr, m_dout, s_dout,
        output m_grant, m_din, m_err, s_sel, s_wr, s_addr, s_din
    );

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din, m_err
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout
    );

endinterface

// File: rtl/bus_matrix_rr_arbiter.sv
// Combinational round-robin pick: first requester after rr_ptr, wrapping modulo N.
module bus_matrix_rr_arbiter
    import bus_matrix_pkg::*;
#(
    parameter int N  = DEF_NUM_MASTERS,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx,
    output logic          any_req
);

    int c;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any_req = 1'b0;
        c       = 0;
        for (int k = 1; k <= N; k++) begin
            c = int'(rr_ptr) + k;
            if (c >= N) c = c - N;
            if (!any_req && c < N && req[c]) begin
                any_req   = 1'b1;
                win_oh[c] = 1'b1;
                win_idx   = PW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_matrix.sv
// Single-layer bus: round-robin grant with lock, window decode to one-hot slave select,
// and registered steering of the 1-cycle slave read data back to the masters.
module bus_matrix
    import bus_matrix_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WIN_LSB     = DEF_WIN_LSB
) (
    input logic          clk,
    input logic          reset,
    bus_matrix_if.matrix bus
);

    localparam int MW = clog2_min1(NUM_MASTERS);
    localparam int SW = clog2_min1(NUM_SLAVES);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    state_t                 state, state_nxt;
    logic [MW-1:0]          owner, owner_nxt, rr_ptr, rr_ptr_nxt, win_idx;
    logic [NUM_MASTERS-1:0] grant_q, grant_nxt, win_oh;
    logic                   any_req;
    bus_req_t               rt;
    logic                   active, hit, err_q, rd_pend;
    logic [SW-1:0]          idx, rd_idx;
    logic [NUM_SLAVES-1:0]  sel;

    bus_matrix_rr_arbiter #(.N(NUM_MASTERS), .PW(MW)) u_arb (
        .req     (bus.m_req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= MW'(NUM_MASTERS - 1);
            grant_q <= '0;
            err_q   <= 1'b0;
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant_q <= grant_nxt;
            err_q   <= active & ~hit;
            rd_pend <= hit & ~rt.wr;
            rd_idx  <= idx;
        end
    end

    // With the owner's request low, the arbiter only sees the other masters, so a
    // release hands the bus over at the next edge without an idle cycle.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_q;
        case (state)
            IDLE: if (any_req) begin
                state_nxt  = BUSY;
                grant_nxt  = win_oh;
                owner_nxt  = win_idx;
                rr_ptr_nxt = win_idx;
            end
            BUSY: if (!bus.m_req[owner]) begin
                if (any_req) begin
                    grant_nxt  = win_oh;
                    owner_nxt  = win_idx;
                    rr_ptr_nxt = win_idx;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rt     = '0;
        active = 1'b0;
        if (state == BUSY && int'(owner) < NUM_MASTERS && bus.m_req[owner]) begin
            active  = 1'b1;
            rt.wr   = bus.m_wr[owner];
            rt.addr = bus.m_addr[owner];
            rt.data = bus.m_dout[owner];
        end
    end

    assign idx = rt.addr[WIN_LSB +: SW];
    assign hit = active && (int'(idx) < NUM_SLAVES) && ((rt.addr >> (WIN_LSB + SW)) == '0);

    always_comb begin
        sel = '0;
        if (hit) sel[idx] = 1'b1;
    end

    assign bus.m_grant = grant_q;
    assign bus.m_err   = err_q;
    assign bus.m_din   = rd_pend ? bus.s_dout[rd_idx] : '0;
    assign bus.s_sel   = sel;
    assign bus.s_wr    = hit & rt.wr;
    assign bus.s_addr  = rt.addr;
    assign bus.s_din   = rt.data;

endmodule
